// File: rtl/panda_risc_v_icb_itcm_slave_pkg.sv
// Shared definitions for the ITCM ICB slave: ICB field widths, error encoding,
// default geometry and the response/in-flight record layouts.
package panda_risc_v_icb_itcm_slave_pkg;

  localparam int unsigned ICB_ADDR_W = 32;
  localparam int unsigned ICB_DATA_W = 32;
  localparam int unsigned ICB_MASK_W = 4;

  localparam logic ERR_OK   = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

  localparam int unsigned ITCM_DEPTH_DEFAULT = 8192;
  localparam int unsigned AW_DEFAULT         = $clog2(ITCM_DEPTH_DEFAULT);

  // One queued response: {err, rdata}
  typedef struct packed {
    logic                  err;
    logic [ICB_DATA_W-1:0] rdata;
  } icb_rsp_t;

  localparam int unsigned RSP_W = $bits(icb_rsp_t);

  // Command accepted last cycle whose SRAM read data arrives this cycle
  typedef struct packed {
    logic valid;
    logic is_read;
    logic err;
  } inflight_t;

  // SRAM byte enables for an accepted, in-range command
  function automatic logic [ICB_MASK_W-1:0] sram_wen(input logic                  is_read,
                                                     input logic [ICB_MASK_W-1:0] wmask,
                                                     input logic                  byte_wr);
    logic [ICB_MASK_W-1:0] wen;
    if (is_read)      wen = '0;
    else if (byte_wr) wen = wmask;
    else              wen = {ICB_MASK_W{|wmask}};
    return wen;
  endfunction

endpackage

// File: rtl/panda_risc_v_icb_itcm_slave_if.sv
// ICB command/response channel between the fetch unit (master) and the ITCM slave.
// Handshake: a channel transfers on a cycle where valid & ready are both high;
// the master holds cmd fields stable while cmd_valid is high and cmd_ready low.
interface panda_risc_v_icb_itcm_slave_if;
  import panda_risc_v_icb_itcm_slave_pkg::*;

  logic [ICB_ADDR_W-1:0] s_icb_cmd_addr;
  logic                  s_icb_cmd_read;
  logic [ICB_DATA_W-1:0] s_icb_cmd_wdata;
  logic [ICB_MASK_W-1:0] s_icb_cmd_wmask;
  logic                  s_icb_cmd_valid;
  logic                  s_icb_cmd_ready;
  logic [ICB_DATA_W-1:0] s_icb_rsp_rdata;
  logic                  s_icb_rsp_err;
  logic                  s_icb_rsp_valid;
  logic                  s_icb_rsp_ready;

  modport master (
    output s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask, s_icb_cmd_valid,
    input  s_icb_cmd_ready,
    input  s_icb_rsp_rdata, s_icb_rsp_err, s_icb_rsp_valid,
    output s_icb_rsp_ready
  );

  modport slave (
    input  s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask, s_icb_cmd_valid,
    output s_icb_cmd_ready,
    output s_icb_rsp_rdata, s_icb_rsp_err, s_icb_rsp_valid,
    input  s_icb_rsp_ready
  );

endinterface

// File: rtl/panda_risc_v_icb_itcm_slave_rsp_fifo.sv
// Two-entry response FIFO. A pop and a push in the same cycle while full are
// both honoured (the pop frees the slot the push takes).
module panda_risc_v_icb_rsp_fifo
  import panda_risc_v_icb_itcm_slave_pkg::*;
#(
  parameter int unsigned W = RSP_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign cnt_o   = cnt_q;
  // Empty FIFO presents zeros rather than a stale entry
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/panda_risc_v_icb_itcm_slave.sv
// ICB slave front-end for the ITCM: turns accepted commands into single-port
// SRAM accesses and returns in-order responses through a 2-entry FIFO.
module panda_risc_v_icb_itcm_slave
  import panda_risc_v_icb_itcm_slave_pkg::*;
#(
  parameter int unsigned  itcm_mem_depth = ITCM_DEPTH_DEFAULT,
  parameter logic [31:0]  itcm_base_addr = 32'h0000_0000,
  parameter string        en_byte_write  = "true",
  localparam int unsigned AW             = $clog2(itcm_mem_depth)
) (
  input  logic                  clk,
  input  logic                  resetn,
  panda_risc_v_icb_itcm_slave_if.slave s_icb,
  output logic                  bram_en,
  output logic [ICB_MASK_W-1:0] bram_wen,
  output logic [AW-1:0]         bram_addr,
  output logic [ICB_DATA_W-1:0] bram_din,
  input  logic [ICB_DATA_W-1:0] bram_dout
);

  localparam bit          BYTE_WR   = (en_byte_write == "true");
  localparam logic [32:0] WIN_BYTES = 33'(itcm_mem_depth) << 2;

  logic [ICB_ADDR_W-1:0] offset;
  logic                  in_range;
  logic                  cmd_fire;
  logic                  rsp_fire;
  logic [1:0]            credits;

  inflight_t inflight_q, inflight_d;

  icb_rsp_t   push_rsp;
  icb_rsp_t   head_rsp;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_cnt;

  // Offset wraps for addresses below the base, which lands them out of range
  assign offset   = s_icb.s_icb_cmd_addr - itcm_base_addr;
  assign in_range = ({1'b0, offset} < WIN_BYTES);

  assign rsp_fire = s_icb.s_icb_rsp_valid & s_icb.s_icb_rsp_ready;
  // Every accepted command owns a FIFO slot before it is accepted, so pushes never stall
  assign credits  = fifo_cnt + {1'b0, inflight_q.valid};
  assign s_icb.s_icb_cmd_ready = (credits < 2'd2) | rsp_fire;
  assign cmd_fire = s_icb.s_icb_cmd_valid & s_icb.s_icb_cmd_ready;

  always_comb begin
    bram_en   = 1'b0;
    bram_wen  = '0;
    bram_addr = offset[2 +: AW];
    bram_din  = s_icb.s_icb_cmd_wdata;
    if (cmd_fire && in_range) begin
      bram_en  = 1'b1;
      bram_wen = sram_wen(s_icb.s_icb_cmd_read, s_icb.s_icb_cmd_wmask, BYTE_WR);
    end
  end

  always_comb begin
    inflight_d.valid   = cmd_fire;
    inflight_d.is_read = s_icb.s_icb_cmd_read;
    inflight_d.err     = in_range ? ERR_OK : ERR_FAIL;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // SRAM data is valid exactly one cycle after the enable, i.e. while inflight is set
  always_comb begin
    push_rsp.err   = inflight_q.err;
    push_rsp.rdata = (inflight_q.is_read && !inflight_q.err) ? bram_dout : '0;
  end

  panda_risc_v_icb_rsp_fifo #(
    .W (RSP_W)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_n_i     (resetn),
    .push_i      (inflight_q.valid),
    .push_data_i (push_rsp),
    .pop_i       (rsp_fire),
    .head_o      (head_rsp),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .cnt_o       (fifo_cnt)
  );

  assign s_icb.s_icb_rsp_valid = ~fifo_empty;
  assign s_icb.s_icb_rsp_rdata = head_rsp.rdata;
  assign s_icb.s_icb_rsp_err   = head_rsp.err;

  a_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
                                   !(inflight_q.valid && fifo_full && !rsp_fire));

endmodule
